t03_layer_compositor: RTL and testbench

//  Parametrised pixel compositor: merges NUM_LAYERS sprite layers, a text layer and a two-band

---
 rtl/t03_layer_compositor.sv | 233 +++++++++++++++++++++++
 tb/tb_t03_layer_compositor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/t03_layer_compositor.sv
// t03_layer_compositor
//   Two-stage pixel compositor: NUM_LAYERS prioritised sprite layers over a text
//   layer over a two-band background, with per-frame sprite collision flags.
//   Optional text blink is compiled in when T03_COMPOSITOR_BLINK_EN is defined;
//   without it text is always visible and text_blink is ignored.
module t03_layer_compositor #(
    parameter int                 NUM_LAYERS   = 4,
    parameter int                 COLOR_W      = 8,
    parameter int                 CNT_W        = 11,
    parameter int                 PF_X_MIN     = 37,
    parameter int                 PF_X_MAX     = 600,
    parameter int                 PF_Y_MIN     = 29,
    parameter int                 PF_Y_SPLIT   = 600,
    parameter int                 PF_Y_MAX     = 800,
    parameter logic [COLOR_W-1:0] SKY_COLOR    = 'h57,
    parameter logic [COLOR_W-1:0] GND_COLOR    = 'h14,
    parameter int                 BLINK_FRAMES = 30
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CNT_W-1:0]                 Hcnt,
    input  logic [CNT_W-1:0]                 Vcnt,
    input  logic [NUM_LAYERS*COLOR_W-1:0]    layer_color,
    input  logic [NUM_LAYERS-1:0]            layer_en,
    input  logic [COLOR_W-1:0]               text_sprite,
    input  logic [COLOR_W-1:0]               text_color,
    input  logic                             text_blink,
    input  logic                             collision_clr,
    output logic [COLOR_W-1:0]               color_out,
    output logic [$clog2(NUM_LAYERS):0]      hit_layer,
    output logic                             collision_live,
    output logic                             collision_frame
);

    localparam int HIT_W = $clog2(NUM_LAYERS) + 1;
    localparam logic [HIT_W-1:0] NO_HIT = HIT_W'(NUM_LAYERS);

    localparam logic [CNT_W-1:0] X_MIN   = CNT_W'(PF_X_MIN);
    localparam logic [CNT_W-1:0] X_MAX   = CNT_W'(PF_X_MAX);
    localparam logic [CNT_W-1:0] Y_MIN   = CNT_W'(PF_Y_MIN);
    localparam logic [CNT_W-1:0] Y_SPLIT = CNT_W'(PF_Y_SPLIT);
    localparam logic [CNT_W-1:0] Y_MAX   = CNT_W'(PF_Y_MAX);

    // ------------------------------------------------------------------
    // Per-layer unpacking and opacity
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0]    lcol [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] opaque;

    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
        assign lcol[gi]   = layer_color[gi*COLOR_W +: COLOR_W];
        assign opaque[gi] = layer_en[gi] && (lcol[gi] != '0);
    end

    // ------------------------------------------------------------------
    // Stage 1 signals
    // ------------------------------------------------------------------
    logic               win_valid_d, win_valid_q;
    logic [HIT_W-1:0]   win_idx_d,   win_idx_q;
    logic [COLOR_W-1:0] win_color_d, win_color_q;
    logic               collide_d,   collide_q;
    logic [COLOR_W-1:0] bg_d,        bg_q;
    logic               fstart_d,    fstart_q;
    logic               text_on_d,   text_on_q;
    logic [COLOR_W-1:0] text_col_d,  text_col_q;
    logic               text_blk_d,  text_blk_q;

    // Stage 1: priority select, overlap detection, background band and frame start
    always_comb begin
        logic multi;
        logic x_in;
        logic y_pf;
        win_valid_d = 1'b0;
        win_idx_d   = NO_HIT;
        win_color_d = '0;
        multi       = 1'b0;
        // Scan from the lowest priority up so the lowest opaque index wins last.
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                if (win_valid_d) begin
                    multi = 1'b1;
                end
                win_valid_d = 1'b1;
                win_idx_d   = HIT_W'(i);
                win_color_d = lcol[i];
            end
        end

        x_in = (Hcnt > X_MIN) && (Hcnt < X_MAX);
        y_pf = (Vcnt > Y_MIN) && (Vcnt < Y_MAX);
        collide_d = multi && x_in && y_pf;

        bg_d = '0;
        if (x_in) begin
            if ((Vcnt > Y_MIN) && (Vcnt < Y_SPLIT)) begin
                bg_d = SKY_COLOR;
            end else if ((Vcnt >= Y_SPLIT) && (Vcnt < Y_MAX)) begin
                bg_d = GND_COLOR;
            end
        end

        fstart_d   = (Hcnt == '0) && (Vcnt == '0);
        text_on_d  = (text_sprite != '0);
        text_col_d = text_color;
        text_blk_d = text_blink;
    end

    // Stage 1 registers; reset clears in-flight pixel data to a blank, no-hit pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid_q <= 1'b0;
            win_idx_q   <= NO_HIT;
            win_color_q <= '0;
            collide_q   <= 1'b0;
            bg_q        <= '0;
            fstart_q    <= 1'b0;
            text_on_q   <= 1'b0;
            text_col_q  <= '0;
            text_blk_q  <= 1'b0;
        end else begin
            win_valid_q <= win_valid_d;
            win_idx_q   <= win_idx_d;
            win_color_q <= win_color_d;
            collide_q   <= collide_d;
            bg_q        <= bg_d;
            fstart_q    <= fstart_d;
            text_on_q   <= text_on_d;
            text_col_q  <= text_col_d;
            text_blk_q  <= text_blk_d;
        end
    end

    // ------------------------------------------------------------------
    // Blink phase
    // ------------------------------------------------------------------
    logic blink_phase;
    logic text_vis;

`ifdef T03_COMPOSITOR_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] frame_cnt_d, frame_cnt_q;
    logic            blink_phase_d, blink_phase_q;

    // Frame counter advances on each frame-start pixel; phase flips on wrap
    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (fstart_q) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Blink state registers; phase starts visible after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign blink_phase = blink_phase_q;
    assign text_vis    = text_on_q && (blink_phase || !text_blk_q);
`else
    logic [1:0] unused_blink;
    assign unused_blink = {text_blk_q, (BLINK_FRAMES >= 1)};
    assign blink_phase  = 1'b1;
    assign text_vis     = text_on_q && blink_phase;
`endif

    // ------------------------------------------------------------------
    // Stage 2 signals
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0] color_out_d, color_out_q;
    logic [HIT_W-1:0]   hit_layer_d, hit_layer_q;
    logic               coll_live_d, coll_live_q;
    logic               coll_frame_d, coll_frame_q;

    // Stage 2: final color mux and collision flag bookkeeping
    always_comb begin
        if (win_valid_q) begin
            color_out_d = win_color_q;
            hit_layer_d = win_idx_q;
        end else if (text_vis) begin
            color_out_d = text_col_q;
            hit_layer_d = NO_HIT;
        end else begin
            color_out_d = bg_q;
            hit_layer_d = NO_HIT;
        end

        coll_frame_d = coll_frame_q;
        coll_live_d  = coll_live_q | collide_q;
        // Clear wins over the frame latch but still records this pixel's overlap.
        if (collision_clr) begin
            coll_frame_d = 1'b0;
            coll_live_d  = collide_q;
        end else if (fstart_q) begin
            coll_frame_d = coll_live_q;
            coll_live_d  = collide_q;
        end
    end

    // Stage 2 output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            color_out_q  <= '0;
            hit_layer_q  <= NO_HIT;
            coll_live_q  <= 1'b0;
            coll_frame_q <= 1'b0;
        end else begin
            color_out_q  <= color_out_d;
            hit_layer_q  <= hit_layer_d;
            coll_live_q  <= coll_live_d;
            coll_frame_q <= coll_frame_d;
        end
    end

    assign color_out       = color_out_q;
    assign hit_layer       = hit_layer_q;
    assign collision_live  = coll_live_q;
    assign collision_frame = coll_frame_q;

endmodule

// File: tb/tb_t03_layer_compositor.sv
// Testbench for t03_layer_compositor: directed pixel sequence, expected
// results queued at drive time and compared when the pixel leaves stage 2.
module tb_t03_layer_compositor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] Hcnt = '0;
    logic [10:0] Vcnt = '0;
    logic [31:0] layer_color = '0;
    logic [3:0]  layer_en = '0;
    logic [7:0]  text_sprite = '0;
    logic [7:0]  text_color = '0;
    logic        text_blink = 1'b0;
    logic        collision_clr = 1'b0;
    logic [7:0]  color_out;
    logic [2:0]  hit_layer;
    logic        collision_live;
    logic        collision_frame;

    t03_layer_compositor #(.BLINK_FRAMES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .Hcnt           (Hcnt),
        .Vcnt           (Vcnt),
        .layer_color    (layer_color),
        .layer_en       (layer_en),
        .text_sprite    (text_sprite),
        .text_color     (text_color),
        .text_blink     (text_blink),
        .collision_clr  (collision_clr),
        .color_out      (color_out),
        .hit_layer      (hit_layer),
        .collision_live (collision_live),
        .collision_frame(collision_frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         h;
        int         v;
        logic       wv;
        logic [2:0] hit;
        logic [7:0] wcol;
        logic       ton;
        logic [7:0] tcol;
        logic       tbl;
        logic [7:0] bg;
        logic       coll;
        logic       fs;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference state at stage-2 time
    logic m_live  = 1'b0;
    logic m_frame = 1'b0;
    int   m_cnt   = 0;
    logic m_phase = 1'b1;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bg_of(input int h, input int v);
        if (h > 37 && h < 600) begin
            if (v > 29 && v < 600) return 8'h57;
            if (v >= 600 && v < 800) return 8'h14;
        end
        return 8'h00;
    endfunction

    // Pop one finished pixel and compare; clr is the value sampled at this edge
    task automatic retire(input logic clr);
        ent_t e;
        logic tvis;
        logic [7:0] ecol;
        logic [2:0] ehit;
        e = q.pop_front();
`ifdef T03_COMPOSITOR_BLINK_EN
        tvis = e.ton && (m_phase || !e.tbl);
`else
        tvis = e.ton;
`endif
        ecol = e.wv ? e.wcol : (tvis ? e.tcol : e.bg);
        ehit = e.wv ? e.hit : 3'd4;
        if (clr) begin
            m_frame = 1'b0;
            m_live  = e.coll;
        end else if (e.fs) begin
            m_frame = m_live;
            m_live  = e.coll;
        end else begin
            m_live = m_live | e.coll;
        end
        if (e.fs) begin
            if (m_cnt == 1) begin
                m_cnt   = 0;
                m_phase = ~m_phase;
            end else begin
                m_cnt++;
            end
        end
        $display("pix (%0d,%0d) color=%02h hit=%0d live=%0b frame=%0b", e.h, e.v,
                 color_out, hit_layer, collision_live, collision_frame);
        chk("color_out", color_out, ecol);
        chk("hit_layer", {5'd0, hit_layer}, {5'd0, ehit});
        chk("collision_live", {7'd0, collision_live}, {7'd0, m_live});
        chk("collision_frame", {7'd0, collision_frame}, {7'd0, m_frame});
    endtask

    // Drive one pixel, queue its expectation, advance one clock
    task automatic pix(input int h, input int v, input logic [31:0] lc, input logic [3:0] en,
                       input logic [7:0] ts, input logic [7:0] tc, input logic tb_,
                       input logic clr);
        ent_t e;
        int   cnt;
        Hcnt = 11'(h); Vcnt = 11'(v);
        layer_color = lc; layer_en = en;
        text_sprite = ts; text_color = tc; text_blink = tb_;
        collision_clr = clr;
        e.h = h; e.v = v;
        e.wv = 1'b0; e.hit = 3'd4; e.wcol = 8'h00; cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (en[i] && lc[i*8 +: 8] != 8'h00) begin
                if (!e.wv) begin
                    e.wv = 1'b1; e.hit = 3'(i); e.wcol = lc[i*8 +: 8];
                end
                cnt++;
            end
        end
        e.ton = (ts != 8'h00); e.tcol = tc; e.tbl = tb_;
        e.bg = bg_of(h, v);
        e.coll = (cnt >= 2) && (h > 37) && (h < 600) && (v > 29) && (v < 800);
        e.fs = (h == 0) && (v == 0);
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() >= 2) retire(clr);
    endtask

    task automatic do_reset(input int n);
        ent_t b;
        q.delete();
        rst = 1'b1;
        layer_color = {8'h11, 8'h22, 8'h33, 8'h44};
        layer_en = 4'hF;
        Hcnt = 11'd200; Vcnt = 11'd200;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("rst_color", color_out, 8'h00);
            chk("rst_hit", {5'd0, hit_layer}, 8'd4);
            chk("rst_live", {7'd0, collision_live}, 8'd0);
            chk("rst_frame", {7'd0, collision_frame}, 8'd0);
        end
        rst = 1'b0;
        m_live = 1'b0; m_frame = 1'b0; m_cnt = 0; m_phase = 1'b1;
        // Cleared stage-1 contents emerge first as a blank pixel
        b.h = -1; b.v = -1; b.wv = 1'b0; b.hit = 3'd4; b.wcol = 8'h00;
        b.ton = 1'b0; b.tcol = 8'h00; b.tbl = 1'b0; b.bg = 8'h00;
        b.coll = 1'b0; b.fs = 1'b0;
        q.push_back(b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] LC_PRIO = {8'h00, 8'h1C, 8'hE0, 8'h00};
    localparam logic [31:0] LC_COLL = {8'h03, 8'h00, 8'h00, 8'h03};

    initial begin
        // Reset with opaque layers present
        do_reset(3);

        // Priority and text fallback
        pix(100, 100, LC_PRIO, 4'b1111, 8'h00, 8'h00, 1'b0, 1'b0);
        pix(100, 100, LC_PRIO, 4'b1101, 8'h00, 8'h00, 1'b0, 1'b0);
        pix(100, 100, 32'h0,   4'b1111, 8'h01, 8'hFF, 1'b0, 1'b0);

        // Background band edges
        pix(37,  100, 32'h0, 4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        pix(38,  100, 32'h0, 4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        pix(38,  599, 32'h0, 4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        pix(38,  600, 32'h0, 4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        pix(38,  799, 32'h0, 4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        pix(38,  800, 32'h0, 4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        pix(600, 100, 32'h0, 4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        pix(38,   29, 32'h0, 4'hF, 8'h00, 8'h00, 1'b0, 1'b0);

        // Collision: set, frame latch, outside-playfield overlap ignored
        pix(200, 200, LC_COLL, 4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        pix(0,   0,   32'h0,   4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        pix(10,  10,  LC_COLL, 4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        pix(300, 300, 32'h0,   4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        pix(300, 300, LC_COLL, 4'h6, 8'h00, 8'h00, 1'b0, 1'b0);

        // Clear: beats frame latch, keeps the coincident pixel's overlap
        pix(200, 200, LC_COLL, 4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        pix(0,   0,   32'h0,   4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        pix(300, 300, LC_COLL, 4'hF, 8'h00, 8'h00, 1'b0, 1'b1);
        pix(300, 301, 32'h0,   4'hF, 8'h00, 8'h00, 1'b0, 1'b1);
        pix(300, 302, 32'h0,   4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        pix(0,   0,   32'h0,   4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        pix(300, 303, 32'h0,   4'hF, 8'h00, 8'h00, 1'b0, 1'b0);

        // Reset mid-stream discards in-flight pixels
        pix(100, 100, LC_PRIO, 4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        do_reset(1);

        // Blink across five frames: blinking and non-blinking text
        for (int f = 0; f < 5; f++) begin
            pix(5,   5, 32'h0, 4'hF, 8'h01, 8'hAA, 1'b1, 1'b0);
            pix(200, 5, 32'h0, 4'hF, 8'h80, 8'hBB, 1'b0, 1'b0);
            pix(0,   0, 32'h0, 4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        end

        // Mixed pixels
        for (int k = 0; k < 24; k++) begin
            pix(int'($urandom_range(0, 700)), int'($urandom_range(0, 900)),
                $urandom & 32'h0F0F0F0F, 4'($urandom), 8'($urandom_range(0, 1)),
                8'($urandom), 1'($urandom), 1'b0);
        end

        // Flush the pipeline
        pix(300, 300, 32'h0, 4'hF, 8'h00, 8'h00, 1'b0, 1'b0);
        pix(300, 300, 32'h0, 4'hF, 8'h00, 8'h00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
